// File: rtl/calc_rr_scheduler_pkg.sv
// calc_pkg: shared op/state encodings and sizing helper for the calculator scheduler
package calc_pkg;
    typedef enum logic [1:0] {OP_ADD, OP_SUB, OP_OR, OP_EQ} calc_op_t;
    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} sched_state_t;
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/calc_rr_scheduler_if.sv
// calc_rr_scheduler_if: request and response channels between requesters, scheduler and consumer
interface calc_rr_scheduler_if #(parameter int NUM_REQ = 2, parameter int WIDTH = 4);
    import calc_pkg::*;
    localparam int ID_W = id_width(NUM_REQ);
    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ-1:0]       req_ready;
    logic [NUM_REQ*WIDTH-1:0] req_a;
    logic [NUM_REQ*WIDTH-1:0] req_b;
    logic [NUM_REQ*2-1:0]     req_op;
    logic                     resp_valid;
    logic                     resp_ready;
    logic [WIDTH-1:0]         resp_data;
    logic [ID_W-1:0]          resp_id;
    modport master (
        output req_valid, req_a, req_b, req_op, resp_ready,
        input  req_ready, resp_valid, resp_data, resp_id
    );
    modport slave (
        input  req_valid, req_a, req_b, req_op, resp_ready,
        output req_ready, resp_valid, resp_data, resp_id
    );
endinterface

// File: rtl/calc_rr_scheduler_alu.sv
// calc_alu: combinational add/sub/or/compare, all results modulo 2**WIDTH
module calc_alu import calc_pkg::*; #(parameter int WIDTH = 4) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  calc_op_t         op,
    output logic [WIDTH-1:0] y
);
    // compare yields 0 on equality, 1 otherwise
    always_comb
        y = (op == OP_ADD) ? a + b :
            (op == OP_SUB) ? a - b :
            (op == OP_OR)  ? a | b : WIDTH'(a != b);
endmodule

// File: rtl/calc_rr_scheduler.sv
// calc_rr_scheduler: round-robin sharing of one calculator ALU between NUM_REQ requesters
module calc_rr_scheduler import calc_pkg::*; #(
    parameter int NUM_REQ = 2,
    parameter int WIDTH   = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic ena,
    output logic busy,
    calc_rr_scheduler_if.slave bus
);
    localparam int ID_W = id_width(NUM_REQ);

    sched_state_t     state_q, state_d;
    logic [ID_W-1:0]  rr_ptr_q, gnt_idx, id_q;
    logic [WIDTH-1:0] a_q, b_q, alu_res;
    calc_op_t         op_q;
    logic             grant;

    // rotate so rr_ptr sits at bit 0, take the lowest valid, rotate the index back
    function automatic logic [ID_W-1:0] rr_pick(input logic [NUM_REQ-1:0] v, input logic [ID_W-1:0] p);
        logic [2*NUM_REQ-1:0] dbl;
        int hit;
        dbl = {v, v} >> p;
        hit = 0;
        for (int i = NUM_REQ - 1; i >= 0; i--)
            if (dbl[i]) hit = i;
        return ID_W'((hit + int'(p)) % NUM_REQ);
    endfunction

    assign gnt_idx        = rr_pick(bus.req_valid, rr_ptr_q);
    assign grant          = rst_n && ena && state_q == S_IDLE && |bus.req_valid;
    assign bus.req_ready  = grant ? NUM_REQ'(1) << gnt_idx : '0;
    assign bus.resp_valid = state_q == S_RESP;
    assign busy           = state_q != S_IDLE;

    calc_alu #(.WIDTH(WIDTH)) u_alu (.a(a_q), .b(b_q), .op(op_q), .y(alu_res));

    // IDLE waits for a grant, EXEC is a single ALU cycle, RESP holds until consumed
    always_comb begin
        state_d = S_IDLE;
        case (state_q)
            S_IDLE:  state_d = grant ? S_EXEC : S_IDLE;
            S_EXEC:  state_d = S_RESP;
            S_RESP:  state_d = bus.resp_ready ? S_IDLE : S_RESP;
            default: state_d = S_IDLE;
        endcase
    end

    // state, operand capture on grant, and result registration at the end of EXEC
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            rr_ptr_q      <= '0;
            a_q           <= '0;
            b_q           <= '0;
            op_q          <= OP_ADD;
            id_q          <= '0;
            bus.resp_data <= '0;
            bus.resp_id   <= '0;
        end else begin
            state_q <= state_d;
            if (grant) begin
                a_q      <= bus.req_a[gnt_idx*WIDTH +: WIDTH];
                b_q      <= bus.req_b[gnt_idx*WIDTH +: WIDTH];
                op_q     <= calc_op_t'(bus.req_op[gnt_idx*2 +: 2]);
                id_q     <= gnt_idx;
                rr_ptr_q <= ID_W'((int'(gnt_idx) + 1) % NUM_REQ);
            end
            if (state_q == S_EXEC) begin
                bus.resp_data <= alu_res;
                bus.resp_id   <= id_q;
            end
        end
    end
endmodule

// File: tb/tb_calc_rr_scheduler.sv
// tb_calc_rr_scheduler: directed and randomized checks of the shared-ALU scheduler
module tb_calc_rr_scheduler;
    import calc_pkg::*;
    localparam int N  = 2;
    localparam int W  = 4;
    localparam int AW = N * W;
    localparam int OW = N * 2;

    logic clk = 0;
    logic rst_n = 0;
    logic ena = 0;
    logic busy;
    int checks = 0;
    int errors = 0;
    int last = N - 1;
    int ra[N];
    int rb[N];
    int ro[N];

    calc_rr_scheduler_if #(.NUM_REQ(N), .WIDTH(W)) bus ();
    calc_rr_scheduler #(.NUM_REQ(N), .WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .ena(ena), .busy(busy), .bus(bus));

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not end, observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] ref_alu(input int a, input int b, input int op);
        case (op)
            0:       return 4'((a + b) % 16);
            1:       return 4'((a - b + 16) % 16);
            2:       return 4'(a | b);
            default: return (a == b) ? 4'd0 : 4'd1;
        endcase
    endfunction

    function automatic int ref_pick(input logic [N-1:0] v);
        for (int i = 1; i <= N; i++)
            if (v[(last + i) % N]) return (last + i) % N;
        return -1;
    endfunction

    task automatic drive(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) begin
            bus.req_a[i*W +: W] = W'(ra[i]);
            bus.req_b[i*W +: W] = W'(rb[i]);
            bus.req_op[i*2 +: 2] = 2'(ro[i]);
        end
        bus.req_valid = v;
    endtask

    task automatic do_reset();
        rst_n = 0;
        ena = 1;
        bus.req_valid = N'($urandom);
        bus.req_a = AW'($urandom);
        bus.req_b = AW'($urandom);
        bus.req_op = OW'($urandom);
        bus.resp_ready = 1'($urandom);
        #1;
        chk("rst_req_ready", bus.req_ready, 0);
        chk("rst_resp_valid", bus.resp_valid, 0);
        chk("rst_resp_data", bus.resp_data, 0);
        chk("rst_resp_id", bus.resp_id, 0);
        chk("rst_busy", busy, 0);
        @(negedge clk);
        chk("rst_hold_busy", busy, 0);
        bus.req_valid = '0;
        bus.resp_ready = 0;
        rst_n = 1;
        last = N - 1;
    endtask

    task automatic run_op(input int id, input logic [3:0] data, input int hold, input bit drop_ena);
        #1;
        chk("grant", bus.req_ready, 32'(1) << id);
        last = id;
        @(negedge clk);
        if (drop_ena) ena = 0;
        chk("exec_busy", busy, 1);
        chk("exec_ready", bus.req_ready, 0);
        chk("exec_resp_valid", bus.resp_valid, 0);
        @(negedge clk);
        for (int k = 0; k <= hold; k++) begin
            chk("resp_valid", bus.resp_valid, 1);
            chk("resp_data", bus.resp_data, data);
            chk("resp_id", bus.resp_id, id);
            chk("resp_ready_gnt", bus.req_ready, 0);
            if (k < hold) @(negedge clk);
        end
        bus.resp_ready = 1;
        @(negedge clk);
        bus.resp_ready = 0;
        chk("post_resp_valid", bus.resp_valid, 0);
        chk("post_busy", busy, 0);
        chk("post_data_hold", bus.resp_data, data);
        chk("post_id_hold", bus.resp_id, id);
    endtask

    initial begin
        int v, w;
        bus.resp_ready = 0;
        do_reset();
        ra[0] = 9; rb[0] = 8; ro[0] = 0; drive(2'b01);
        run_op(0, 4'd1, 0, 0);
        ra[0] = 3; rb[0] = 5; ro[0] = 1; drive(2'b01);
        run_op(0, 4'd14, 0, 0);
        ra[0] = 10; rb[0] = 5; ro[0] = 2; drive(2'b01);
        run_op(0, 4'd15, 0, 0);
        ra[0] = 7; rb[0] = 7; ro[0] = 3; drive(2'b01);
        run_op(0, 4'd0, 0, 0);
        ra[0] = 7; rb[0] = 6; ro[0] = 3; drive(2'b01);
        run_op(0, 4'd1, 0, 0);
        do_reset();
        ra[0] = 1; rb[0] = 2; ro[0] = 0;
        ra[1] = 6; rb[1] = 4; ro[1] = 1;
        drive(2'b11);
        run_op(0, 4'd3, 0, 0);
        run_op(1, 4'd2, 0, 0);
        run_op(0, 4'd3, 0, 0);
        run_op(1, 4'd2, 0, 0);
        ra[0] = 4; rb[0] = 3; ro[0] = 0;
        ra[1] = 5; rb[1] = 5; ro[1] = 3;
        drive(2'b11);
        run_op(0, 4'd7, 10, 0);
        run_op(1, 4'd0, 0, 0);
        ena = 0;
        #1 chk("ena_low_ready", bus.req_ready, 0);
        @(negedge clk);
        chk("ena_low_busy", busy, 0);
        chk("ena_low_ready2", bus.req_ready, 0);
        ena = 1;
        run_op(0, 4'd7, 2, 1);
        #1 chk("ena_dropped_ready", bus.req_ready, 0);
        ena = 1;
        drive(2'b01);
        #1 chk("midop_grant", bus.req_ready, 1);
        @(negedge clk);
        chk("midop_busy", busy, 1);
        rst_n = 0;
        drive(2'b00);
        #1;
        chk("midop_rst_valid", bus.resp_valid, 0);
        chk("midop_rst_busy", busy, 0);
        chk("midop_rst_data", bus.resp_data, 0);
        @(negedge clk);
        rst_n = 1;
        last = N - 1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("midop_no_resp", bus.resp_valid, 0);
        end
        drive(2'b11);
        run_op(0, 4'd7, 0, 0);
        for (int t = 0; t < 80; t++) begin
            v = $urandom_range(0, 3);
            ena = ($urandom_range(0, 5) != 0);
            for (int i = 0; i < N; i++) begin
                ra[i] = $urandom_range(0, 15);
                rb[i] = $urandom_range(0, 15);
                ro[i] = $urandom_range(0, 3);
            end
            drive(N'(v));
            w = ena ? ref_pick(N'(v)) : -1;
            if (w < 0) begin
                #1 chk("rand_no_grant", bus.req_ready, 0);
                @(negedge clk);
                chk("rand_idle_busy", busy, 0);
            end else begin
                run_op(w, ref_alu(ra[w], rb[w], ro[w]), $urandom_range(0, 3), 0);
            end
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
